// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding a single FIFO write port
//
// Purpose:
//    Grants one of NUM_REQ requesters access to a FIFO write port for a burst
//    of up to MAX_BURST beats. Requesters are served round-robin. After a
//    burst, the search restarts at the requester following the one just
//    served. Arbitration takes one IDLE cycle. During BURST the granted
//    requester's data/valid pass straight through to the FIFO. The FIFO ready
//    passes straight back to that requester.
//
// Ports:
//    clkIn         in   single clock, rising edge
//    rstIn         in   asynchronous active-high reset
//    reqDataIn     in   NUM_REQ x DATA_WIDTH packed requester data (req i at [i*DATA_WIDTH +: DATA_WIDTH])
//    reqValidIn    in   per-requester valid
//    reqReadyOut   out  per-requester ready (only the granted one can be high)
//    wrDataOut     out  data to FIFO write side, 0 outside BURST
//    wrValidOut    out  valid to FIFO write side
//    wrReadyIn     in   ready from FIFO write side
//    grantOut      out  one-hot current grant, zero when idle
//    busyOut       out  high while in BURST
//    statBeatsOut  out  (only with FIFO_ARB_STATS_EN) NUM_REQ x 16-bit saturating beat counters
//
// Optional feature macro: FIFO_ARB_STATS_EN

module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 8
) (
   input  logic                          clkIn,
   input  logic                          rstIn,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
   input  logic [NUM_REQ-1:0]            reqValidIn,
   output logic [NUM_REQ-1:0]            reqReadyOut,
   output logic [DATA_WIDTH-1:0]         wrDataOut,
   output logic                          wrValidOut,
   input  logic                          wrReadyIn,
   output logic [NUM_REQ-1:0]            grantOut,
   output logic                          busyOut
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         statBeatsOut
`endif
);

   localparam int               IDX_W     = $clog2(NUM_REQ);
   localparam logic [7:0]       LAST_BEAT = 8'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]    gidx_q, gidx_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [7:0]          beat_cnt_q, beat_cnt_d;

   logic                  in_burst;
   logic                  g_valid;
   logic [DATA_WIDTH-1:0] g_data;
   logic                  beat;
   logic                  burst_end;
   logic                  scan_found;
   logic [IDX_W-1:0]      scan_idx;
   logic [IDX_W-1:0]      cand;

   // First valid requester at or above rr_ptr_q, wrapping past NUM_REQ-1.
   always_comb begin
      scan_found = 1'b0;
      scan_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!scan_found && reqValidIn[cand]) begin
            scan_found = 1'b1;
            scan_idx   = cand;
         end
      end
   end

   // Select the granted requester's data and valid.
   always_comb begin
      g_data  = '0;
      g_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx_q == IDX_W'(i)) begin
            g_data  = reqDataIn[i*DATA_WIDTH +: DATA_WIDTH];
            g_valid = reqValidIn[i];
         end
      end
   end

   assign in_burst    = (state_q == ST_BURST);
   assign wrValidOut  = in_burst & g_valid;
   assign wrDataOut   = in_burst ? g_data : '0;
   // grant_q is zero outside BURST, so this is only ever the granted bit.
   assign reqReadyOut = grant_q & {NUM_REQ{wrReadyIn & in_burst}};
   assign grantOut    = grant_q;
   assign busyOut     = in_burst;

   assign beat      = wrValidOut & wrReadyIn;
   // A requester dropping valid ends its burst even if it was mid-stall.
   assign burst_end = in_burst & (~g_valid | (beat & (beat_cnt_q == LAST_BEAT)));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (scan_found) begin
               state_d    = ST_BURST;
               gidx_d     = scan_idx;
               grant_d    = NUM_REQ'(1) << scan_idx;
               beat_cnt_d = '0;
            end
         end
         ST_BURST: begin
            if (burst_end) begin
               state_d    = ST_IDLE;
               grant_d    = '0;
               beat_cnt_d = '0;
               rr_ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDX_W'(1);
            end else if (beat) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stat_q [NUM_REQ];
   logic [15:0] stat_d [NUM_REQ];

   always_comb begin
      statBeatsOut = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_d[i] = stat_q[i];
         if (beat && (gidx_q == IDX_W'(i)) && (stat_q[i] != 16'hFFFF)) begin
            stat_d[i] = stat_q[i] + 16'd1;
         end
         statBeatsOut[i*16 +: 16] = stat_q[i];
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= stat_d[i];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int MB = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [DW-1:0]    wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic [NR-1:0]    grant;
   logic             busy;
`ifdef FIFO_ARB_STATS_EN
   logic [NR*16-1:0] stat_beats;
`endif

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
      .clkIn       (clk),
      .rstIn       (rst),
      .reqDataIn   (req_data),
      .reqValidIn  (req_valid),
      .reqReadyOut (req_ready),
      .wrDataOut   (wr_data),
      .wrValidOut  (wr_valid),
      .wrReadyIn   (wr_ready),
      .grantOut    (grant),
      .busyOut     (busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .statBeatsOut(stat_beats)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NR-1:0] grant;
      logic [DW-1:0] data;
      int            gap;
   } beat_t;

   beat_t sb[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    rem[NR];
   int    seq[NR];
   int    exp_seq[NR];
   int    cyc = 0;
   int    last_beat_cyc = 0;
   int    n_popped = 0;
   logic  wr_rdy = 1'b1;
   logic  sb_on = 1'b1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]         = (rem[i] > 0);
         req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
      end
      wr_ready = wr_rdy;
   endtask

   task automatic push(input int g, input int n, input int gap_first);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.grant = NR'(1) << g;
         b.data  = {8'(g), 24'(exp_seq[g])};
         b.gap   = (k == 0) ? gap_first : 1;
         exp_seq[g]++;
         sb.push_back(b);
      end
   endtask

   task automatic step();
      logic [NR-1:0] hs;
      beat_t         b;
      @(negedge clk);
      if (sb_on) begin
         if (wr_valid && wr_ready) begin
            if (sb.size() == 0) begin
               check("spurious_beat", wr_valid, 1'b0);
            end else begin
               b = sb.pop_front();
               n_popped++;
               check("beat_data", wr_data, b.data);
               check("beat_grant", grant, b.grant);
               check("beat_ready", req_ready, b.grant);
               check("beat_busy", busy, 1);
               if (b.gap != 0) check("beat_gap", cyc - last_beat_cyc, b.gap);
            end
            last_beat_cyc = cyc;
         end else if (busy && !wr_ready && sb.size() > 0) begin
            check("stall_grant", grant, sb[0].grant);
            check("stall_data", wr_data, sb[0].data);
            check("stall_ready", req_ready, 0);
         end
      end
      hs = req_ready & req_valid;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NR; i++) begin
         if (hs[i]) begin
            seq[i]++;
            rem[i]--;
         end
      end
      drive();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() > 0 && n < budget) begin
         step();
         n++;
      end
      if (sb.size() > 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic wait_popped(input int target, input int budget);
      int n = 0;
      while (n_popped < target && n < budget) begin
         step();
         n++;
      end
      if (n_popped < target) check("pop_timeout", n_popped, target);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < NR; i++) rem[i] = 0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      for (int i = 0; i < NR; i++) exp_seq[i] = seq[i];
      rst = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_wrvalid"}, wr_valid, 0);
      check({tag, "_wrdata"}, wr_data, 0);
      check({tag, "_ready"}, req_ready, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < NR; i++) begin
         rem[i]     = 1;
         seq[i]     = 0;
         exp_seq[i] = 0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");

      for (int i = 0; i < NR; i++) rem[i] = 0;
      drive();
      rst = 1'b0;

      // Single requester, 3 beats, then next scan from req2.
      rem[1] = 3;
      drive();
      last_beat_cyc = cyc;
      check("s1_pre_grant", grant, 0);
      check("s1_pre_wrvalid", wr_valid, 0);
      push(1, 3, 1);
      drain(20);
      step();
      step();
      check_idle("s1_end");
      rem[0] = 1;
      rem[2] = 1;
      drive();
      last_beat_cyc = cyc;
      push(2, 1, 1);
      push(0, 1, 3);
      drain(20);
      step();
      step();

      // All requesters continuously valid: 0,1,2,3,0 bursts of MB beats.
      do_reset();
      for (int i = 0; i < NR; i++) rem[i] = 2 * MB;
      drive();
      last_beat_cyc = cyc;
      push(0, MB, 1);
      push(1, MB, 2);
      push(2, MB, 2);
      push(3, MB, 2);
      push(0, MB, 2);
      drain(200);
      for (int i = 0; i < NR; i++) rem[i] = 0;
      drive();
      step();
      step();
      check_idle("s2_end");

      // FIFO backpressure for 5 cycles after beat 3.
      do_reset();
      rem[0] = 12;
      drive();
      last_beat_cyc = cyc;
      push(0, 3, 1);
      push(0, 5, 6);
      push(0, 4, 2);
      n_popped = 0;
      wait_popped(3, 20);
      wr_rdy = 1'b0;
      drive();
      repeat (5) step();
      wr_rdy = 1'b1;
      drive();
      drain(100);
      step();
      step();
      check_idle("s3_end");

      // Pointer at 2 with req0 and req3 waiting: req3 first.
      do_reset();
      rem[1] = 1;
      drive();
      last_beat_cyc = cyc;
      push(1, 1, 1);
      drain(20);
      rem[0] = 2;
      rem[3] = 2;
      drive();
      push(3, 2, 3);
      push(0, 2, 3);
      drain(50);
      step();
      step();

      // Asynchronous reset at beat 4, then scan restarts from req0.
      do_reset();
      rem[0] = 20;
      drive();
      last_beat_cyc = cyc;
      push(0, MB, 1);
      n_popped = 0;
      wait_popped(4, 20);
      #2;
      rst = 1'b1;
      #1;
      check_idle("s5_async");
      sb.delete();
      for (int i = 0; i < NR; i++) begin
         rem[i]     = 0;
         exp_seq[i] = seq[i];
      end
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;
      rem[0] = 1;
      rem[2] = 1;
      drive();
      last_beat_cyc = cyc;
      push(0, 1, 1);
      push(2, 1, 3);
      drain(50);
      step();
      step();

`ifdef FIFO_ARB_STATS_EN
      do_reset();
      sb_on  = 1'b0;
      rem[0] = 70000;
      drive();
      begin
         int n = 0;
         while (rem[0] > 0 && n < 80000) begin
            step();
            n++;
         end
      end
      check("stat_req0_sat", stat_beats[15:0], 16'hFFFF);
      for (int i = 1; i < NR; i++) check("stat_other", stat_beats[i*16 +: 16], 0);
      sb_on = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
